dpll_bitsync: RTL and testbench

//  Digital-PLL bit synchroniser for the 50 kbit/s DPSK receive path; consumer of clk_div output.

---
 rtl/dpll_bitsync_pkg.sv | 18 +
 rtl/dpll_rw_filter.sv | 48 ++++
 rtl/dpll_bitsync.sv | 150 +++++++++++++++
 tb/tb_dpll_bitsync.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_bitsync_pkg.sv
// Shared defaults and encodings for the DPLL bit synchroniser.
// The phase counter advances by one of three step sizes per div_clk tick.
package dpll_bitsync_pkg;

  localparam int DEF_DIV_N    = 64;
  localparam int DEF_CNT_W    = 6;
  localparam int DEF_AVG_K    = 4;
  localparam int DEF_LOCK_WIN = 2;
  localparam int DEF_LOCK_CNT = 8;

  // Step size applied to the phase counter on a tick.
  typedef enum logic [1:0] {
    STEP_DEL  = 2'd0,
    STEP_NORM = 2'd1,
    STEP_ADD  = 2'd2
  } step_e;

endpackage

// File: rtl/dpll_rw_filter.sv
// Random-walk loop filter: accumulates early/late votes.
// Issues a single add/drop request when |acc| reaches AVG_K.
module dpll_rw_filter
  import dpll_bitsync_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int AVG_K = DEF_AVG_K
) (
  input  logic clk100m,
  input  logic clr,
  input  logic vote_early,
  input  logic vote_late,
  output logic add_req,
  output logic del_req
);

  localparam int ACC_W = CNT_W + 1;
  localparam logic signed [ACC_W-1:0] K_POS = ACC_W'(AVG_K);
  localparam logic signed [ACC_W-1:0] K_NEG = ACC_W'(-AVG_K);
  localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_sum;

  // Threshold is tested on the post-vote value so a request fires in the vote cycle.
  always_comb begin
    acc_sum = acc_reg;
    if (vote_late) begin
      acc_sum = acc_reg + ONE;
    end else if (vote_early) begin
      acc_sum = acc_reg - ONE;
    end
  end

  assign add_req = vote_late  && (acc_sum == K_POS);
  assign del_req = vote_early && (acc_sum == K_NEG);

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      acc_reg <= '0;
    end else if (add_req || del_req) begin
      acc_reg <= '0;
    end else if (vote_early || vote_late) begin
      acc_reg <= acc_sum;
    end
  end

endmodule

// File: rtl/dpll_bitsync.sv
// DPLL bit synchroniser: counts div_clk ticks as phase, steers phase from data
// transitions via a random-walk filter, samples mid-bit and tracks lock.
module dpll_bitsync
  import dpll_bitsync_pkg::*;
#(
  parameter int DIV_N    = DEF_DIV_N,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_K    = DEF_AVG_K,
  parameter int LOCK_WIN = DEF_LOCK_WIN,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic clk100m,
  input  logic clr,
  input  logic div_clk,
  input  logic data_in,
  output logic bit_clk,
  output logic bit_data,
  output logic bit_valid,
  output logic lock
);

  localparam int LC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(DIV_N / 2);
  localparam logic [CNT_W-1:0] WIN    = CNT_W'(LOCK_WIN);
  localparam logic [CNT_W-1:0] ZERO   = '0;
  localparam logic [LC_W-1:0]  LC_MAX = LC_W'(LOCK_CNT);
  localparam logic [LC_W-1:0]  LC_ONE = LC_W'(1);

  logic [2:0]       div_sync_reg;
  logic [1:0]       data_sync_reg;
  logic             tick;
  logic             data_s;
  logic             transition;
  logic             d_tick_reg;
  logic [CNT_W-1:0] ph_cnt_reg;
  logic [CNT_W-1:0] ph_next;
  logic [CNT_W-1:0] ph_err;
  logic             pend_add_reg;
  logic             pend_del_reg;
  logic             pend_any;
  step_e            step_sel;
  logic             vote_early;
  logic             vote_late;
  logic             add_req;
  logic             del_req;
  logic             crossing;
  logic             good;
  logic [LC_W-1:0]  lock_cnt_reg;
  logic [LC_W-1:0]  lock_cnt_next;

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      div_sync_reg  <= '0;
      data_sync_reg <= '0;
    end else begin
      div_sync_reg  <= {div_sync_reg[1:0], div_clk};
      data_sync_reg <= {data_sync_reg[0], data_in};
    end
  end

  assign tick       = div_sync_reg[1] & ~div_sync_reg[2];
  assign data_s     = data_sync_reg[1];
  assign transition = tick & (data_s ^ d_tick_reg);

  always_comb begin
    step_sel = STEP_NORM;
    if (pend_add_reg) begin
      step_sel = STEP_ADD;
    end else if (pend_del_reg) begin
      step_sel = STEP_DEL;
    end
  end

  // DIV_N is a power of two, so the counter width provides the modulo.
  assign ph_next  = ph_cnt_reg + CNT_W'(step_sel);
  assign crossing = (ph_cnt_reg < HALF) && (ph_next >= HALF);
  assign pend_any = pend_add_reg | pend_del_reg;

  assign vote_early = transition && (ph_cnt_reg != ZERO) && (ph_cnt_reg < HALF);
  assign vote_late  = transition && (ph_cnt_reg >= HALF);

  assign ph_err = (ph_cnt_reg < HALF) ? ph_cnt_reg : (ZERO - ph_cnt_reg);
  assign good   = (ph_err <= WIN);

  dpll_rw_filter #(
    .CNT_W (CNT_W),
    .AVG_K (AVG_K)
  ) u_filter (
    .clk100m    (clk100m),
    .clr        (clr),
    .vote_early (vote_early),
    .vote_late  (vote_late),
    .add_req    (add_req),
    .del_req    (del_req)
  );

  // A pending correction is consumed on the tick it applies; a request arriving
  // while one is still pending is discarded rather than stacked.
  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      ph_cnt_reg   <= '0;
      d_tick_reg   <= 1'b0;
      pend_add_reg <= 1'b0;
      pend_del_reg <= 1'b0;
    end else if (tick) begin
      ph_cnt_reg   <= ph_next;
      d_tick_reg   <= data_s;
      pend_add_reg <= add_req & ~pend_any;
      pend_del_reg <= del_req & ~pend_any;
    end
  end

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
      bit_clk   <= 1'b0;
    end else begin
      bit_valid <= tick & crossing;
      if (tick) begin
        bit_clk <= (ph_next >= HALF);
      end
      if (tick && crossing) begin
        bit_data <= d_tick_reg;
      end
    end
  end

  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (transition) begin
      if (!good) begin
        lock_cnt_next = '0;
      end else if (lock_cnt_reg != LC_MAX) begin
        lock_cnt_next = lock_cnt_reg + LC_ONE;
      end
    end
  end

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      lock_cnt_reg <= '0;
      lock         <= 1'b0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
      lock         <= (lock_cnt_next == LC_MAX);
    end
  end

endmodule

// File: tb/tb_dpll_bitsync.sv
// Scoreboard bench for dpll_bitsync: tick-level reference model, randomized edges.
module tb_dpll_bitsync;

  localparam int DIV_N    = 16;
  localparam int CNT_W    = 4;
  localparam int AVG_K    = 4;
  localparam int LOCK_WIN = 1;
  localparam int LOCK_CNT = 4;

  logic clk100m = 1'b0;
  logic clr     = 1'b1;
  logic div_clk = 1'b0;
  logic data_in = 1'b0;
  logic bit_clk, bit_data, bit_valid, lock;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;

  typedef struct {
    bit data;
    bit lock;
  } exp_t;
  exp_t sb_q[$];

  int m_ph, m_acc, m_lcnt;
  bit m_pa, m_pd, m_dt, m_bclk, m_lock;

  dpll_bitsync #(
    .DIV_N    (DIV_N),
    .CNT_W    (CNT_W),
    .AVG_K    (AVG_K),
    .LOCK_WIN (LOCK_WIN),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk100m   (clk100m),
    .clr       (clr),
    .div_clk   (div_clk),
    .data_in   (data_in),
    .bit_clk   (bit_clk),
    .bit_data  (bit_data),
    .bit_valid (bit_valid),
    .lock      (lock)
  );

  always #5 clk100m = ~clk100m;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_acc = 0; m_lcnt = 0;
    m_pa = 0; m_pd = 0; m_dt = 0; m_bclk = 0; m_lock = 0;
  endtask

  // One div_clk period of the reference: phase step, vote, filter, sample, lock.
  task automatic model_tick(input bit v);
    int p, step, nph, err;
    bit trans, pend;
    exp_t e;
    p     = m_ph;
    trans = (v != m_dt);
    pend  = m_pa | m_pd;
    step  = m_pa ? 2 : (m_pd ? 0 : 1);
    m_pa  = 0;
    m_pd  = 0;
    if (trans && p != 0) begin
      m_acc += (p >= DIV_N / 2) ? 1 : -1;
      if (m_acc == AVG_K) begin
        m_acc = 0;
        if (!pend) m_pa = 1;
      end else if (m_acc == -AVG_K) begin
        m_acc = 0;
        if (!pend) m_pd = 1;
      end
    end
    if (trans) begin
      err = (p < DIV_N / 2) ? p : DIV_N - p;
      if (err <= LOCK_WIN) m_lcnt = (m_lcnt < LOCK_CNT) ? m_lcnt + 1 : LOCK_CNT;
      else m_lcnt = 0;
      m_lock = (m_lcnt == LOCK_CNT);
    end
    nph = (p + step) % DIV_N;
    if (p < DIV_N / 2 && nph >= DIV_N / 2) begin
      e.data = m_dt;
      e.lock = m_lock;
      sb_q.push_back(e);
    end
    m_bclk = (nph >= DIV_N / 2);
    m_ph   = nph;
    m_dt   = v;
  endtask

  task automatic do_tick(input bit v);
    @(negedge clk100m);
    div_clk = 1'b1;
    data_in = v;
    model_tick(v);
    repeat (3) @(posedge clk100m);
    @(negedge clk100m);
    check1("bit_clk", bit_clk, m_bclk);
    check1("lock", lock, m_lock);
    @(negedge clk100m);
    div_clk = 1'b0;
    repeat (2) @(negedge clk100m);
  endtask

  task automatic do_reset();
    check1("strobes_drained", sb_q.size() == 0, 1'b1);
    @(negedge clk100m);
    clr = 1'b0;
    #1;
    check1("rst_bit_clk", bit_clk, 1'b0);
    check1("rst_bit_data", bit_data, 1'b0);
    check1("rst_bit_valid", bit_valid, 1'b0);
    check1("rst_lock", lock, 1'b0);
    model_reset();
    sb_q.delete();
    repeat (3) @(negedge clk100m);
    clr = 1'b1;
  endtask

  task automatic tick_until(input int target);
    int n;
    n = 0;
    while (m_ph != target && n < 2 * DIV_N) begin
      do_tick(m_dt);
      n++;
    end
    if (m_ph != target) begin
      errors++;
      $display("FAIL tick_until: phase %0d not reached at %0t", target, $time);
    end
  endtask

  task automatic run_edges(input int n_trans, input int gap_lo, input int gap_hi);
    bit cur;
    cur = m_dt;
    for (int t = 0; t < n_trans; t++) begin
      int len;
      len = $urandom_range(gap_hi, gap_lo);
      cur = ~cur;
      for (int k = 0; k < len; k++) do_tick(cur);
    end
  endtask

  always @(negedge clk100m) begin
    if (clr && bit_valid) begin
      exp_t e;
      strobes++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: got unexpected bit_valid, expected none at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        $display("strobe %0d: bit_data=%0b lock=%0b", strobes, bit_data, lock);
        if (bit_data !== e.data || lock !== e.lock) begin
          errors++;
          $display("FAIL strobe: got data=%0b lock=%0b expected data=%0b lock=%0b at %0t",
                   bit_data, lock, e.data, e.lock, $time);
        end
      end
    end
  end

  initial begin
    int s0;
    #2 clr = 1'b0;
    repeat (3) @(negedge clk100m);
    check1("init_bit_clk", bit_clk, 1'b0);
    check1("init_bit_data", bit_data, 1'b0);
    check1("init_bit_valid", bit_valid, 1'b0);
    check1("init_lock", lock, 1'b0);
    model_reset();
    clr = 1'b1;

    // Constant data: four strobes over 64 ticks, never locked.
    s0 = strobes;
    for (int i = 0; i < 64; i++) do_tick(1'b0);
    check1("const_strobes", (strobes - s0) == 4, 1'b1);
    check1("const_lock", lock, 1'b0);

    // Mid-run reset while bit_clk is high.
    tick_until(9);
    check1("pre_rst_bit_clk", bit_clk, 1'b1);
    do_reset();
    s0 = strobes;
    for (int i = 0; i < 8; i++) do_tick(1'b0);
    check1("post_rst_strobe", (strobes - s0) == 1, 1'b1);

    // Aligned alternating data.
    do_reset();
    tick_until(0);
    run_edges(8, 16, 16);
    check1("aligned_lock", lock, 1'b1);

    // Late edges, pulled in by add corrections.
    do_reset();
    tick_until(12);
    run_edges(24, 16, 16);
    check1("late_lock", lock, 1'b1);

    // Early edges, pulled back by drop corrections.
    do_reset();
    tick_until(3);
    run_edges(20, 16, 16);
    check1("early_lock", lock, 1'b1);

    // Randomized jitter.
    do_reset();
    run_edges(40, 10, 22);
    check1("final_drained", sb_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
